// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer and its return stack.
package pc_sequencer_pkg;

    localparam int PC_WIDTH    = 10;
    localparam int STACK_DEPTH = 8;
    localparam int PTR_WIDTH   = $clog2(STACK_DEPTH);
    localparam int CNT_WIDTH   = $clog2(STACK_DEPTH + 1);

    localparam logic [PC_WIDTH-1:0] ISR_VECTOR = 10'h3FF;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_INTR  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_JMP  = 3'd1,
        BR_BRCC = 3'd2,
        BR_CALL = 3'd3,
        BR_RET  = 3'd4,
        BR_RETI = 3'd5,
        BR_SEI  = 3'd6,
        BR_CLI  = 3'd7
    } br_type_t;

    // Return address for CALL; wraps at the top of the address space.
    function automatic logic [PC_WIDTH-1:0] pc_plus_one(input logic [PC_WIDTH-1:0] pc);
        return pc + PC_WIDTH'(1);
    endfunction

endpackage

// File: rtl/pc_sequencer_stack.sv
// Eight-deep LIFO return-address stack; occupancy is reset, storage is not.
module pc_stack
    import pc_sequencer_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 push,
    input  logic                 pop,
    input  logic [PC_WIDTH-1:0]  din,
    output logic [PC_WIDTH-1:0]  dout,
    output logic                 full,
    output logic                 empty,
    output logic [CNT_WIDTH-1:0] count
);

    logic [PC_WIDTH-1:0]  mem [STACK_DEPTH];
    logic [CNT_WIDTH-1:0] count_q;
    logic [PTR_WIDTH-1:0] wr_idx;
    logic [PTR_WIDTH-1:0] top_idx;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count_q == CNT_WIDTH'(STACK_DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign wr_idx  = count_q[PTR_WIDTH-1:0];
    assign top_idx = count_q[PTR_WIDTH-1:0] - PTR_WIDTH'(1);
    assign dout    = mem[top_idx];

    // Push wins if both are requested, so occupancy moves by at most one.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty && !push;

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
        end else if (do_push) begin
            count_q <= count_q + CNT_WIDTH'(1);
        end else if (do_pop) begin
            count_q <= count_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push && !RST) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute/interrupt sequencer driving PC load/increment strobes and a return stack.
//
// state | meaning
// INIT  | post-reset idle, all strobes low
// FETCH | latch instruction register
// EXEC  | execute strobe, PC action decoded from BR_TYPE
// INTR  | push return PC, vector to ISR, acknowledge interrupt
module pc_sequencer
    import pc_sequencer_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    input  logic [2:0]          BR_TYPE,
    input  logic                COND,
    input  logic [PC_WIDTH-1:0] TARGET,
    input  logic [PC_WIDTH-1:0] PC_COUNT,
    input  logic                INTR,
    output logic                PC_LD,
    output logic                PC_INC,
    output logic [PC_WIDTH-1:0] PC_DIN,
    output logic                IR_LD,
    output logic                EXEC_EN,
    output logic                INT_ACK,
    output logic                I_EN,
    output logic                STK_FULL,
    output logic                STK_EMPTY,
    output logic                STK_ERR
);

    state_t               state_q;
    state_t               state_d;
    logic                 i_en_q;
    logic                 i_en_d;
    logic                 err_q;
    logic                 err_set;
    br_type_t             br;

    logic                 stk_push;
    logic                 stk_pop;
    logic [PC_WIDTH-1:0]  stk_din;
    logic [PC_WIDTH-1:0]  stk_dout;
    logic                 stk_full;
    logic                 stk_empty;
    logic [CNT_WIDTH-1:0] stk_count;

    assign br        = br_type_t'(BR_TYPE);
    assign I_EN      = i_en_q;
    assign STK_ERR   = err_q;
    assign STK_FULL  = (stk_count == CNT_WIDTH'(STACK_DEPTH));
    assign STK_EMPTY = (stk_count == '0);

    pc_stack u_stack (
        .CLK   (CLK),
        .RST   (RST),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (stk_din),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty),
        .count (stk_count)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_INIT;
            i_en_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_en_q  <= i_en_d;
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        i_en_d   = i_en_q;
        err_set  = 1'b0;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_din  = PC_COUNT;
        PC_LD    = 1'b0;
        PC_INC   = 1'b0;
        PC_DIN   = '0;
        IR_LD    = 1'b0;
        EXEC_EN  = 1'b0;
        INT_ACK  = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                IR_LD   = 1'b1;
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                EXEC_EN = 1'b1;
                unique case (br)
                    BR_JMP: begin
                        PC_LD  = 1'b1;
                        PC_DIN = TARGET;
                    end
                    BR_BRCC: begin
                        if (COND) begin
                            PC_LD  = 1'b1;
                            PC_DIN = TARGET;
                        end else begin
                            PC_INC = 1'b1;
                        end
                    end
                    BR_CALL: begin
                        if (!stk_full) begin
                            stk_push = 1'b1;
                            stk_din  = pc_plus_one(PC_COUNT);
                            PC_LD    = 1'b1;
                            PC_DIN   = TARGET;
                        end else begin
                            err_set = 1'b1;
                            PC_INC  = 1'b1;
                        end
                    end
                    BR_RET, BR_RETI: begin
                        // A failed return still re-enables interrupts for RETI.
                        if (!stk_empty) begin
                            stk_pop = 1'b1;
                            PC_LD   = 1'b1;
                            PC_DIN  = stk_dout;
                        end else begin
                            err_set = 1'b1;
                            PC_INC  = 1'b1;
                        end
                        if (br == BR_RETI) begin
                            i_en_d = 1'b1;
                        end
                    end
                    BR_SEI: begin
                        PC_INC = 1'b1;
                        i_en_d = 1'b1;
                    end
                    BR_CLI: begin
                        PC_INC = 1'b1;
                        i_en_d = 1'b0;
                    end
                    default: begin
                        PC_INC = 1'b1;
                    end
                endcase
                // Interrupt gating looks at the post-instruction enable value.
                state_d = (INTR && i_en_d) ? ST_INTR : ST_FETCH;
            end

            ST_INTR: begin
                INT_ACK = 1'b1;
                PC_LD   = 1'b1;
                PC_DIN  = ISR_VECTOR;
                i_en_d  = 1'b0;
                if (!stk_full) begin
                    stk_push = 1'b1;
                    stk_din  = PC_COUNT;
                end else begin
                    err_set = 1'b1;
                end
                state_d = ST_FETCH;
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a queue-based behavioural model checked every cycle.
module tb_pc_sequencer;

    localparam int P_INIT  = 0;
    localparam int P_FETCH = 1;
    localparam int P_EXEC  = 2;
    localparam int P_INTR  = 3;

    localparam logic [2:0] NONE = 3'd0, JMP = 3'd1, BRCC = 3'd2, CALL = 3'd3,
                           RET  = 3'd4, RETI = 3'd5, SEI = 3'd6, CLI = 3'd7;

    logic       CLK = 1'b0;
    logic       RST;
    logic [2:0] BR_TYPE;
    logic       COND;
    logic [9:0] TARGET;
    logic [9:0] PC_COUNT;
    logic       INTR;
    logic       PC_LD, PC_INC, IR_LD, EXEC_EN, INT_ACK, I_EN;
    logic       STK_FULL, STK_EMPTY, STK_ERR;
    logic [9:0] PC_DIN;

    int passed = 0;
    int total  = 0;
    bit cmp_on = 1'b0;

    // Behavioural model state
    int         m_phase = P_INIT;
    bit         m_ien   = 1'b0;
    bit         m_err   = 1'b0;
    logic [9:0] m_stk[$];
    logic [9:0] m_ret;
    bit         m_ien_n;

    logic       e_ld, e_inc, e_ir, e_ex, e_ack;
    logic [9:0] e_din;

    pc_sequencer dut (
        .CLK       (CLK),
        .RST       (RST),
        .BR_TYPE   (BR_TYPE),
        .COND      (COND),
        .TARGET    (TARGET),
        .PC_COUNT  (PC_COUNT),
        .INTR      (INTR),
        .PC_LD     (PC_LD),
        .PC_INC    (PC_INC),
        .PC_DIN    (PC_DIN),
        .IR_LD     (IR_LD),
        .EXEC_EN   (EXEC_EN),
        .INT_ACK   (INT_ACK),
        .I_EN      (I_EN),
        .STK_FULL  (STK_FULL),
        .STK_EMPTY (STK_EMPTY),
        .STK_ERR   (STK_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    always @(posedge CLK) begin
        if (RST) begin
            m_phase = P_INIT;
            m_ien   = 1'b0;
            m_err   = 1'b0;
            m_stk.delete();
        end else begin
            case (m_phase)
                P_INIT:  m_phase = P_FETCH;
                P_FETCH: m_phase = P_EXEC;
                P_EXEC: begin
                    m_ien_n = m_ien;
                    case (BR_TYPE)
                        CALL: begin
                            if (m_stk.size() < 8) begin
                                m_ret = PC_COUNT + 10'd1;
                                m_stk.push_back(m_ret);
                            end else begin
                                m_err = 1'b1;
                            end
                        end
                        RET, RETI: begin
                            if (m_stk.size() > 0) void'(m_stk.pop_back());
                            else m_err = 1'b1;
                            if (BR_TYPE == RETI) m_ien_n = 1'b1;
                        end
                        SEI: m_ien_n = 1'b1;
                        CLI: m_ien_n = 1'b0;
                        default: ;
                    endcase
                    m_ien   = m_ien_n;
                    m_phase = (INTR && m_ien_n) ? P_INTR : P_FETCH;
                end
                default: begin
                    if (m_stk.size() < 8) m_stk.push_back(PC_COUNT);
                    else m_err = 1'b1;
                    m_ien   = 1'b0;
                    m_phase = P_FETCH;
                end
            endcase
        end
    end

    always @(negedge CLK) begin
        if (cmp_on) begin
            e_ld = 0; e_inc = 0; e_ir = 0; e_ex = 0; e_ack = 0; e_din = '0;
            case (m_phase)
                P_FETCH: e_ir = 1;
                P_EXEC: begin
                    e_ex = 1;
                    case (BR_TYPE)
                        JMP: begin e_ld = 1; e_din = TARGET; end
                        BRCC: if (COND) begin e_ld = 1; e_din = TARGET; end else e_inc = 1;
                        CALL: if (m_stk.size() < 8) begin e_ld = 1; e_din = TARGET; end else e_inc = 1;
                        RET, RETI: if (m_stk.size() > 0) begin e_ld = 1; e_din = m_stk[$]; end else e_inc = 1;
                        default: e_inc = 1;
                    endcase
                end
                P_INTR: begin e_ack = 1; e_ld = 1; e_din = 10'h3FF; end
                default: ;
            endcase
            chk("pc_ld", PC_LD, e_ld);
            chk("pc_inc", PC_INC, e_inc);
            chk("pc_din", PC_DIN, e_din);
            chk("ir_ld", IR_LD, e_ir);
            chk("exec_en", EXEC_EN, e_ex);
            chk("int_ack", INT_ACK, e_ack);
            chk("i_en", I_EN, m_ien);
            chk("stk_full", STK_FULL, m_stk.size() == 8);
            chk("stk_empty", STK_EMPTY, m_stk.size() == 0);
            chk("stk_err", STK_ERR, m_err);
        end
    end

    // Waits for FETCH, drives junk there (must be ignored), then presents the
    // instruction in EXEC and returns at the EXEC negedge.
    task automatic instr(input logic [2:0] br, input logic c, input logic [9:0] tgt,
                         input logic [9:0] pc, input logic irq);
        int n = 0;
        while (m_phase != P_FETCH && n < 8) begin
            @(negedge CLK);
            n++;
        end
        chk("fetch_ir_ld", IR_LD, 1);
        #1;
        BR_TYPE  = 3'($urandom);
        COND     = 1'($urandom);
        TARGET   = 10'($urandom);
        INTR     = 1'($urandom);
        @(posedge CLK);
        #1;
        BR_TYPE  = br;
        COND     = c;
        TARGET   = tgt;
        PC_COUNT = pc;
        INTR     = irq;
        @(negedge CLK);
    endtask

    task automatic next_cycle();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1; BR_TYPE = NONE; COND = 0; TARGET = '0; PC_COUNT = '0; INTR = 0;
        repeat (2) @(posedge CLK);
        #1;
        RST    = 1'b0;
        cmp_on = 1'b1;
        @(negedge CLK);
        chk("init_ir_ld", IR_LD, 0);
        chk("init_pc_din", PC_DIN, 10'h000);
        chk("init_empty", STK_EMPTY, 1);
        chk("init_full", STK_FULL, 0);

        instr(NONE, 0, 10'h000, 10'h010, 0);
        chk("first_exec_inc", PC_INC, 1);
        chk("first_exec_empty", STK_EMPTY, 1);
        chk("first_exec_ien", I_EN, 0);

        instr(BRCC, 1, 10'h120, 10'h011, 0);
        chk("brcc_taken_ld", PC_LD, 1);
        chk("brcc_taken_din", PC_DIN, 10'h120);
        instr(BRCC, 0, 10'h120, 10'h120, 0);
        chk("brcc_not_inc", PC_INC, 1);
        chk("brcc_not_ld", PC_LD, 0);
        instr(JMP, 0, 10'h2AA, 10'h121, 1);
        chk("jmp_din", PC_DIN, 10'h2AA);

        instr(CALL, 0, 10'h040, 10'h3FF, 0);
        chk("call_wrap_din", PC_DIN, 10'h040);
        instr(NONE, 0, 10'h000, 10'h040, 0);
        instr(RET, 0, 10'h000, 10'h041, 0);
        chk("ret_wrap_din", PC_DIN, 10'h000);
        next_cycle();
        chk("ret_wrap_empty", STK_EMPTY, 1);

        for (int i = 0; i < 9; i++) begin
            instr(CALL, 0, 10'(10'h300 + i), 10'(10'h100 + i * 16), 0);
            if (i == 7) begin
                next_cycle();
                chk("eight_calls_full", STK_FULL, 1);
            end
            if (i == 8) begin
                chk("ninth_call_inc", PC_INC, 1);
                next_cycle();
                chk("ninth_call_err", STK_ERR, 1);
            end
        end
        for (int i = 0; i < 9; i++) begin
            instr(RET, 0, 10'h000, 10'h200, 0);
            if (i == 0) chk("first_ret_din", PC_DIN, 10'h171);
            if (i == 8) begin
                chk("ninth_ret_inc", PC_INC, 1);
                next_cycle();
                chk("ninth_ret_err", STK_ERR, 1);
            end
        end

        instr(SEI, 0, 10'h000, 10'h055, 1);
        chk("sei_ien_before_edge", I_EN, 0);
        next_cycle();
        chk("sei_int_ack", INT_ACK, 1);
        chk("sei_vector", PC_DIN, 10'h3FF);
        next_cycle();
        chk("isr_ien_cleared", I_EN, 0);
        instr(CLI, 0, 10'h000, 10'h3FF, 1);
        next_cycle();
        chk("cli_no_ack", INT_ACK, 0);
        chk("cli_to_fetch", IR_LD, 1);
        instr(RETI, 0, 10'h000, 10'h200, 1);
        chk("reti_din", PC_DIN, 10'h055);
        next_cycle();
        chk("reti_reenter_ack", INT_ACK, 1);
        next_cycle();

        instr(CALL, 0, 10'h300, 10'h210, 0);
        instr(CALL, 0, 10'h310, 10'h301, 0);
        instr(SEI, 0, 10'h000, 10'h311, 1);
        next_cycle();
        chk("pre_reset_ack", INT_ACK, 1);
        chk("pre_reset_err", STK_ERR, 1);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_intr_empty", STK_EMPTY, 1);
        chk("rst_intr_ien", I_EN, 0);
        chk("rst_intr_err", STK_ERR, 0);
        chk("rst_intr_ir_ld", IR_LD, 0);

        instr(RETI, 0, 10'h000, 10'h010, 0);
        chk("reti_empty_inc", PC_INC, 1);
        next_cycle();
        chk("reti_empty_ien", I_EN, 1);
        chk("reti_empty_err", STK_ERR, 1);

        do_reset();
        instr(SEI, 0, 10'h000, 10'h001, 0);
        for (int i = 0; i < 8; i++) begin
            instr(CALL, 0, 10'(10'h080 + i), 10'(10'h020 + i), 0);
        end
        instr(NONE, 0, 10'h000, 10'h0AA, 1);
        next_cycle();
        chk("full_intr_ack", INT_ACK, 1);
        chk("full_intr_vector", PC_DIN, 10'h3FF);
        next_cycle();
        chk("full_intr_err", STK_ERR, 1);
        chk("full_intr_still_full", STK_FULL, 1);
        chk("full_intr_ien", I_EN, 0);

        repeat (2) @(negedge CLK);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, ports as follows:
- CLK  in  1  rising-edge clock for all state.
- RST  in  1  synchronous, active-high reset.
REQ-002 SHALL have the following data/control ports:
- BR_TYPE  in  3  decoded flow class: 0 NONE, 1 JMP, 2 BRCC, 3 CALL, 4 RET, 5 RETI, 6 SEI, 7 CLI.
- COND  in  1  branch condition for BRCC.
- TARGET  in  10  jump/call destination.
- PC_COUNT  in  10  current program-counter value.
- INTR  in  1  level interrupt request.
- PC_LD  out  1  load PC from PC_DIN.
- PC_INC  out  1  increment PC.
- PC_DIN  out  10  PC load value.
- IR_LD  out  1  latch instruction register.
- EXEC_EN  out  1  datapath execute strobe.
- INT_ACK  out  1  interrupt accepted.
- I_EN  out  1  interrupt-enable flag.
- STK_FULL  out  1  stack holds 8 entries.
- STK_EMPTY  out  1  stack holds 0 entries.
- STK_ERR  out  1  sticky overflow/underflow flag.

Function
REQ-003 SHALL implement FSM states INIT, FETCH, EXEC, INTR.
- Transitions: INIT->FETCH; FETCH->EXEC; EXEC->INTR if interrupt is taken (REQ-010), else EXEC->FETCH; INTR->FETCH.
REQ-004 SHALL assert IR_LD only in FETCH, EXEC_EN only in EXEC, and INT_ACK only in INTR, each for exactly one cycle.
REQ-005 SHALL never assert PC_LD and PC_INC in the same cycle, and SHALL assert neither outside EXEC and INTR.
REQ-006 In EXEC, the PC action by BR_TYPE SHALL be:
- NONE, SEI, CLI: PC_INC.
- JMP: PC_LD, PC_DIN=TARGET.
- BRCC: PC_LD with PC_DIN=TARGET if COND=1, else PC_INC.
REQ-007 CALL in EXEC, when not full, SHALL push PC_COUNT+1 (mod 1024, so 10'h3FF pushes 10'h000) and assert PC_LD with PC_DIN=TARGET.
REQ-008 RET and RETI in EXEC, when not empty, SHALL pop and assert PC_LD with PC_DIN=popped value; RETI SHALL also set I_EN.
REQ-009 SEI SHALL set I_EN and CLI SHALL clear it, both effective on the next edge.
REQ-010 An interrupt SHALL be taken in EXEC iff INTR=1 and the post-instruction I_EN value is 1.
- Consequences: CLI blocks an interrupt in the same cycle; SEI and RETI allow one immediately.
REQ-011 The current instruction's PC action SHALL complete in EXEC before the INTR state is entered.
REQ-012 In INTR, the block SHALL:
- push PC_COUNT unmodified;
- assert PC_LD with PC_DIN=10'h3FF;
- clear I_EN;
- assert INT_ACK.
REQ-013 The stack SHALL be 8 entries of 10 bits, LIFO.
- STK_FULL and STK_EMPTY are combinational from the occupancy count.
- At most one push or pop occurs per cycle.
REQ-014 CALL when full SHALL NOT push and SHALL set STK_ERR; it executes as PC_INC.
REQ-015 RET or RETI when empty SHALL NOT pop and SHALL set STK_ERR; it executes as PC_INC.
- RETI on empty still sets I_EN.
REQ-016 INTR state when full SHALL NOT push and SHALL set STK_ERR, but SHALL still vector to 10'h3FF and clear I_EN.
REQ-017 STK_ERR SHALL remain set until RST.
REQ-018 BR_TYPE, COND, TARGET and INTR SHALL be ignored outside EXEC.

Reset
REQ-019 RST=1 at a rising edge SHALL override all other activity, including mid-EXEC and mid-INTR. It SHALL set:
- state=INIT;
- I_EN=0;
- stack occupancy=0;
- STK_ERR=0.
REQ-020 While in INIT, all strobes (PC_LD, PC_INC, IR_LD, EXEC_EN, INT_ACK) SHALL be 0, PC_DIN SHALL be 0, STK_EMPTY SHALL be 1 and STK_FULL SHALL be 0.
REQ-021 Stack storage contents SHALL NOT require reset.

Structure
REQ-022 A shared package SHALL hold:
- the state enum;
- the BR_TYPE enum;
- ISR_VECTOR=10'h3FF;
- STACK_DEPTH=8;
- PC_WIDTH=10.
REQ-023 The stack SHALL be a sub-module pc_stack with ports:
- push, pop, din, dout, full, empty, count;
- synchronous, active-high reset.
REQ-024 All outputs SHALL be combinational decodes of the registered state, I_EN and stack state plus EXEC-cycle inputs; there SHALL be no latches.

Verification
REQ-025 Reset then run 3 cycles with BR_TYPE=NONE:
- INIT, then FETCH (IR_LD=1), then EXEC (PC_INC=1);
- STK_EMPTY=1, I_EN=0.
REQ-026 BRCC with TARGET=10'h120:
- COND=1: PC_LD=1, PC_DIN=10'h120.
- COND=0: PC_INC=1, PC_LD=0.
REQ-027 CALL at PC_COUNT=10'h3FF with TARGET=10'h040, then RET:
- CALL: PC_DIN=10'h040.
- Later RET: PC_DIN=10'h000, STK_EMPTY=1.
REQ-028 Nine successive CALLs: STK_FULL=1 after the 8th; the 9th gives PC_INC=1 and STK_ERR=1. Then nine RETs: the 9th gives PC_INC=1 and STK_ERR stays 1.
REQ-029 Interrupt cases:
- SEI with INTR=1: next state INTR, INT_ACK=1, PC_DIN=10'h3FF, I_EN->0.
- CLI with INTR=1: next state FETCH, no INT_ACK.
- RETI from ISR with INTR held: re-enters INTR.
REQ-030 Assert RST during INTR with the stack at 3 entries: next cycle state=INIT, STK_EMPTY=1, I_EN=0, STK_ERR=0.
